// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetch buffer between imem and IF/ID.
// Redirects flush the queue and turn every outstanding fetch into a discard.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pcplus4
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = AW + 4;

   logic [31:0]   q_inst [DEPTH];
   logic [31:0]   q_pc4  [DEPTH];
   logic [31:0]   tag    [DEPTH];
   logic [AW-1:0] q_wp, q_rp, t_wp, t_rp;
   logic [CW-1:0] occ, inflight;
   logic [DW-1:0] drop;
   logic          accept, rsp, rsp_live, pop;

   // inflight counts live fetches only; fetches killed by a redirect live in drop
   always_comb begin
      imem_req_valid = !rst && !redirect && (({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(DEPTH));
      inst_valid     = occ != '0 && !redirect;
      accept         = imem_req_valid && imem_req_ready;
      rsp            = imem_rsp_valid && (inflight != '0 || drop != '0);
      rsp_live       = rsp && drop == '0;
      pop            = inst_valid && inst_ready;
      inst_data      = q_inst[q_rp];
      inst_pcplus4   = q_pc4[q_rp];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_req_addr <= RESET_PC;
         q_wp          <= '0;
         q_rp          <= '0;
         t_wp          <= '0;
         t_rp          <= '0;
         occ           <= '0;
         inflight      <= '0;
         drop          <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc4[i]  <= '0;
            tag[i]    <= '0;
         end
      end else if (redirect) begin
         imem_req_addr <= redirect_pc;
         occ           <= '0;
         q_rp          <= q_wp;
         inflight      <= '0;
         t_rp          <= t_wp;
         drop          <= drop + DW'(inflight) - DW'(rsp);
      end else begin
         if (accept) begin
            imem_req_addr <= imem_req_addr + 32'd4;
            tag[t_wp]     <= imem_req_addr + 32'd4;
            t_wp          <= t_wp + AW'(1);
         end
         if (rsp && drop != '0)
            drop <= drop - DW'(1);
         if (rsp_live) begin
            q_inst[q_wp] <= imem_rsp_data;
            q_pc4[q_wp]  <= tag[t_rp];
            q_wp         <= q_wp + AW'(1);
            t_rp         <= t_rp + AW'(1);
         end
         if (pop)
            q_rp <= q_rp + AW'(1);
         inflight <= inflight + CW'(accept) - CW'(rsp_live);
         occ      <= occ + CW'(rsp_live) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random checks of ifetch_queue against a
// request-list model with an in-order variable-latency memory.
module tb_ifetch_queue;
   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 0, rst = 1, redirect = 0, imem_req_ready = 0, imem_rsp_valid = 0, inst_ready = 0;
   logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pcplus4;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pcplus4(inst_pcplus4)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit live; } req_t;
   typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;
   req_t        out_q[$];
   ent_t        exp_q[$];
   int          checks = 0, failures = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, deliveries = 0;
   logic [31:0] mpc = RESET_PC, last_pc4 = 0;
   bit          spurious = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hc3a5, ~a[17:2]};
   endfunction

   function automatic int live_cnt();
      int n = 0;
      foreach (out_q[i]) if (out_q[i].live) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit iready, input bit rready);
      bit   rv, acc, pp;
      req_t r;
      ent_t e;
      redirect = redir; redirect_pc = rpc; inst_ready = iready; imem_req_ready = rready;
      rv = !rst && out_q.size() > 0 && out_q[0].due <= cyc;
      imem_rsp_valid = rv || spurious;
      imem_rsp_data  = rv ? mem_word(out_q[0].addr) : 32'hdead_beef;
      #1;
      if (rst) begin
         check("req_valid_in_rst", imem_req_valid, 0);
         out_q.delete(); exp_q.delete(); mpc = RESET_PC; last_due = 0;
      end else begin
         check("req_valid", imem_req_valid, !redir && (exp_q.size() + live_cnt() < DEPTH));
         check("inst_valid", inst_valid, exp_q.size() != 0 && !redir);
         check("req_addr", imem_req_addr, mpc);
         acc = imem_req_valid && rready;
         pp  = inst_valid && iready;
         if (pp && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inst_data", inst_data, e.inst);
            check("inst_pcplus4", inst_pcplus4, e.pc4);
            last_pc4 = inst_pcplus4;
            deliveries++;
         end
         if (rv) begin
            r = out_q.pop_front();
            if (r.live && !redir) exp_q.push_back('{mem_word(r.addr), r.addr + 32'd4});
         end
         if (redir) begin
            exp_q.delete();
            foreach (out_q[i]) out_q[i].live = 0;
            mpc = rpc;
         end
         if (acc) begin
            r.addr = mpc;
            r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (r.due <= last_due) r.due = last_due + 1;
            r.live = 1;
            last_due = r.due;
            out_q.push_back(r);
            mpc += 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_delivery(input string tag, input logic [31:0] exp_pc4);
      int d0 = deliveries, n = 0;
      while (deliveries == d0 && n < 40) begin
         step(0, 0, 1, 1);
         n++;
      end
      check({tag, "_timeout"}, 32'(deliveries != d0), 1);
      check(tag, last_pc4, exp_pc4);
   endtask

   initial begin
      int d0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      rst = 0;
      #1;
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_inst_pcplus4", inst_pcplus4, 0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check("rst_req_valid", imem_req_valid, 1);

      // streaming, 1-cycle memory: pops from cycle 2 onward, one per cycle
      for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
      check("stream_count", deliveries, 18);
      check("stream_last_pc4", last_pc4, 32'h48);

      // backpressure: queue fills to DEPTH and fetching stops
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
      check("bp_req_valid", imem_req_valid, 0);
      check("bp_inst_valid", inst_valid, 1);
      d0 = deliveries;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      check("bp_drain_count", deliveries - d0, 4);
      check("bp_drained", inst_valid, 0);

      // protocol error: response with nothing outstanding is ignored
      spurious = 1;
      step(0, 0, 1, 0);
      spurious = 0;
      step(0, 0, 1, 0);

      // redirect with three fetches in flight on a 3-cycle memory
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
      check("rd_inflight", out_q.size(), 3);
      step(1, 32'h100, 1, 1);
      wait_delivery("rd_first_pc4", 32'h104);

      // redirect coinciding with a response and a pending pop
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
      check("rd2_rsp_pending", 32'(out_q.size() > 0 && out_q[0].due <= cyc), 1);
      check("rd2_pop_pending", inst_valid, 1);
      step(1, 32'h200, 1, 1);
      wait_delivery("rd2_first_pc4", 32'h204);

      // random traffic with a mid-run reset
      lat_lo = 1; lat_hi = 5;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst = 1;
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
            rst = 0;
         end
         step($urandom_range(0, 19) == 0, $urandom & 32'h0000_fffc,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
      end
      check("random_progress", 32'(deliveries > 1000), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
